// File: rtl/output_control_pkg.sv
// Shared definitions for the bit-serial result transmitter: FSM state
// encoding and the lane-slicing convention used on flat result buses.
package output_control_pkg;

  // Transmitter states. The 2-bit encoding matches the operand loader so
  // both ends of the array decode the same values in waveforms.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Total number of serial bits in one frame of n lanes, w bits each.
  function automatic int frame_bits(input int n, input int w);
    return n * w;
  endfunction

  // Index of the LSB of lane `lane` on a flat bus of w-bit lanes.
  // Lane 0 sits in the lowest bits, so the frame leaves lane 0 first
  // when the bus is shifted out LSB first.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/output_control_if.sv
// Handshake and data bundle between the array result outputs, the
// transmitter, and the off-chip serial link.
interface output_control_if #(
  parameter int N     = 2,
  parameter int OUT_W = 16
);

  logic [N*OUT_W-1:0] data_in_z_flat;
  logic               capture;
  logic               start;
  logic               data_out_z;
  logic               out_valid;
  logic               out_first;
  logic               busy;
  logic               done;
  logic               overrun;

  // The side that presents results and issues capture/start.
  modport master (
    output data_in_z_flat,
    output capture,
    output start,
    input  data_out_z,
    input  out_valid,
    input  out_first,
    input  busy,
    input  done,
    input  overrun
  );

  // The transmitter itself.
  modport slave (
    input  data_in_z_flat,
    input  capture,
    input  start,
    output data_out_z,
    output out_valid,
    output out_first,
    output busy,
    output done,
    output overrun
  );

endinterface

// File: rtl/output_control_piso_shift.sv
// Parallel-in serial-out register: loads a whole word in one cycle and
// shifts right by one bit per enabled cycle, presenting the LSB.
module piso_shift #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             lsb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load wins over shift so a fresh capture is never corrupted by a
  // concurrent shift request; zeros fill in from the top.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = data_in;
    end else if (shift) begin
      data_d = {1'b0, data_q[WIDTH-1:1]};
    end
  end

  // Buffer register, cleared on reset so no stale results leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign lsb = data_q[0];

endmodule

// File: rtl/output_control.sv
// Bit-serial result transmitter. Captures N result lanes in one cycle and
// sends them on a single line, lane 0 first and LSB first, with valid and
// first-bit markers. All outputs come from flops.
module output_control
  import output_control_pkg::*;
#(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int OUT_W = 2 * D_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output_control_if.slave       bus
);

  localparam int FRAME_W = frame_bits(N, OUT_W);
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             overrun_q;
  logic             overrun_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             out_first_q;
  logic             out_first_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic             buf_load;
  logic             buf_shift;
  logic             buf_lsb;

  // State register; reset aborts any frame in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: capture outranks start, and is refused only while
  // a frame is being shifted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.capture) begin
          state_d = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (!bus.capture && bus.start) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = bus.capture ? ST_LOADED : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath control: buffer load/shift, bit counter and the sticky
  // overrun flag. The counter holds at the last index when SHIFT ends,
  // so it never wraps.
  always_comb begin
    buf_load  = bus.capture && (state_q != ST_SHIFT);
    buf_shift = (state_q == ST_SHIFT);

    cnt_d = cnt_q;
    if ((state_q != ST_SHIFT) && (state_d == ST_SHIFT)) begin
      cnt_d = '0;
    end else if ((state_q == ST_SHIFT) && (cnt_q != LAST_BIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    overrun_d = overrun_q;
    if ((state_q == ST_SHIFT) && bus.capture) begin
      overrun_d = 1'b1;
    end else if (buf_load) begin
      overrun_d = 1'b0;
    end
  end

  // Counter and overrun registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Output decode from the upcoming state, so each output flop holds the
  // value for the cycle that state will occupy.
  always_comb begin
    out_valid_d = (state_d == ST_SHIFT);
    out_first_d = (state_d == ST_SHIFT) && (cnt_d == '0);
    busy_d      = (state_d == ST_SHIFT);
    done_d      = (state_d == ST_DONE);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  piso_shift #(
    .WIDTH (FRAME_W)
  ) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (buf_load),
    .shift   (buf_shift),
    .data_in (bus.data_in_z_flat),
    .lsb     (buf_lsb)
  );

  assign bus.data_out_z = buf_lsb & out_valid_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_first  = out_first_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_output_control.sv
// Self-checking bench for output_control: directed scenarios followed by
// randomized frames, checked against a frame-level reference model.
module tb_output_control;
  import output_control_pkg::*;

  localparam int D_W     = 8;
  localparam int N       = 2;
  localparam int OUT_W   = 16;
  localparam int FRAME_W = N * OUT_W;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;
  logic ovr_model;

  output_control_if #(.N(N), .OUT_W(OUT_W)) bus ();

  output_control #(.D_W(D_W), .N(N), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle stamp used to measure frame-to-frame spacing.
  always @(posedge clk) cycle_no <= cycle_no + 1;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] pack(input logic [OUT_W-1:0] z0,
                                              input logic [OUT_W-1:0] z1);
    logic [FRAME_W-1:0] f;
    f = '0;
    f |= FRAME_W'(z0) << lane_lsb(0, OUT_W);
    f |= FRAME_W'(z1) << lane_lsb(1, OUT_W);
    return f;
  endfunction

  function automatic logic [FRAME_W-1:0] rand_frame();
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int r = 0; r < N; r++) begin
      f |= FRAME_W'(OUT_W'($urandom())) << lane_lsb(r, OUT_W);
    end
    return f;
  endfunction

  // One clock of stimulus; capture/start are single-cycle pulses.
  task automatic apply_stimulus(input logic cap, input logic st,
                                input logic [FRAME_W-1:0] data);
    bus.capture        = cap;
    bus.start          = st;
    bus.data_in_z_flat = data;
    tick();
    bus.capture = 1'b0;
    bus.start   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_bit({tag, ".valid"}, bus.out_valid, 1'b0);
    check_bit({tag, ".first"}, bus.out_first, 1'b0);
    check_bit({tag, ".busy"},  bus.busy,      1'b0);
    check_bit({tag, ".data"},  bus.data_out_z, 1'b0);
  endtask

  // Starts a frame from LOADED and checks every bit plus the DONE cycle.
  // cap_at >= 0 raises capture while that bit is on the line.
  task automatic run_frame(input logic [FRAME_W-1:0] frame, input int cap_at,
                           output int first_cyc, output int last_cyc);
    first_cyc = 0;
    last_cyc  = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < FRAME_W; j++) begin
      if (j == 0) first_cyc = cycle_no;
      check_bit($sformatf("valid[%0d]", j), bus.out_valid, 1'b1);
      check_bit($sformatf("first[%0d]", j), bus.out_first, j == 0);
      check_bit($sformatf("bit[%0d]", j), bus.data_out_z, frame[j]);
      check_bit($sformatf("busy[%0d]", j), bus.busy, 1'b1);
      check_bit($sformatf("done[%0d]", j), bus.done, 1'b0);
      check_bit($sformatf("overrun[%0d]", j), bus.overrun, ovr_model);
      last_cyc = cycle_no;
      if (j == cap_at) begin
        bus.capture        = 1'b1;
        bus.data_in_z_flat = rand_frame();
        ovr_model          = 1'b1;
      end
      tick();
      bus.capture = 1'b0;
    end
    check_bit("done_pulse", bus.done, 1'b1);
    check_quiet("done_cycle");
    check_bit("done_overrun", bus.overrun, ovr_model);
  endtask

  initial begin
    logic [FRAME_W-1:0] f;
    logic [FRAME_W-1:0] g;
    int fc1, lc1, fc2, lc2;
    int cap_at;

    rst_n              = 1'b0;
    bus.capture        = 1'b0;
    bus.start          = 1'b0;
    bus.data_in_z_flat = '0;
    ovr_model          = 1'b0;
    #12;
    check_quiet("reset");
    check_bit("reset.done", bus.done, 1'b0);
    check_bit("reset.overrun", bus.overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] start in IDLE");
    apply_stimulus(1'b0, 1'b1, '0);
    check_quiet("idle_start0");
    tick();
    check_quiet("idle_start1");

    $display("[TB] basic frame");
    f = pack(16'h00A5, 16'h8001);
    apply_stimulus(1'b1, 1'b0, f);
    run_frame(f, -1, fc1, lc1);
    apply_stimulus(1'b0, 1'b0, '0);
    check_bit("basic.after_done", bus.done, 1'b0);
    check_quiet("basic.idle");

    $display("[TB] recapture in LOADED");
    apply_stimulus(1'b1, 1'b0, pack(16'h1111, 16'h2222));
    f = pack(16'h3333, 16'h4444);
    apply_stimulus(1'b1, 1'b0, f);
    run_frame(f, -1, fc1, lc1);
    apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] capture and start together");
    apply_stimulus(1'b1, 1'b0, pack(16'hAAAA, 16'h5555));
    f = pack(16'hC3C3, 16'h0FF0);
    apply_stimulus(1'b1, 1'b1, f);
    check_quiet("capstart0");
    tick();
    check_quiet("capstart1");
    run_frame(f, -1, fc1, lc1);
    apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] capture during SHIFT");
    f = pack(16'hBEEF, 16'h1234);
    apply_stimulus(1'b1, 1'b0, f);
    run_frame(f, 5, fc1, lc1);
    apply_stimulus(1'b0, 1'b0, '0);
    check_bit("overrun.idle", bus.overrun, 1'b1);
    f = pack(16'h0F0F, 16'hF00F);
    apply_stimulus(1'b1, 1'b0, f);
    ovr_model = 1'b0;
    check_bit("overrun.cleared", bus.overrun, 1'b0);

    $display("[TB] back-to-back frames");
    run_frame(f, -1, fc1, lc1);
    g = pack(16'h7E57, 16'h9ABC);
    apply_stimulus(1'b1, 1'b0, g);
    run_frame(g, -1, fc2, lc2);
    check_int("b2b.spacing", fc2 - lc1, 3);
    apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] reset mid-frame");
    f = pack(16'hFFFF, 16'hFFFF);
    apply_stimulus(1'b1, 1'b0, f);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    check_bit("midrst.valid_before", bus.out_valid, 1'b1);
    check_bit("midrst.bit10", bus.data_out_z, f[10]);
    rst_n = 1'b0;
    #1;
    check_quiet("midrst.async");
    check_bit("midrst.done", bus.done, 1'b0);
    tick();
    check_bit("midrst.done_held", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ovr_model = 1'b0;
    tick();
    apply_stimulus(1'b0, 1'b1, '0);
    check_quiet("postrst.start0");
    check_bit("postrst.done", bus.done, 1'b0);
    tick();
    check_quiet("postrst.start1");

    $display("[TB] randomized frames");
    for (int it = 0; it < 8; it++) begin
      f = rand_frame();
      apply_stimulus(1'b1, 1'b0, f);
      ovr_model = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        f = rand_frame();
        apply_stimulus(1'b1, 1'b0, f);
      end
      cap_at = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, FRAME_W - 1));
      run_frame(f, cap_at, fc1, lc1);
      apply_stimulus(1'b0, 1'b0, '0);
      check_bit($sformatf("rand%0d.idle_overrun", it), bus.overrun, ovr_model);
      check_quiet($sformatf("rand%0d.idle", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
